// File: rtl/quad_pkg.sv
// Shared constants and decode helper for the quadrature decoder.
// Phases are written {B,A}; counting up walks 00 -> 01 -> 11 -> 10 -> 00.
package quad_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_UP,
    EV_DOWN,
    EV_ILLEGAL
  } quad_event_e;

  function automatic logic [1:0] next_up(input logic [1:0] phase);
    case (phase)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchronizer followed by a run-length filter: the output only follows
// the synced input after FILTER_LEN consecutive disagreeing samples.
module quad_input_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] run;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      run   <= '0;
      filt  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any agreeing sample restarts the run, so short glitches never reach filt.
      if (sync2 == filt) begin
        run <= '0;
      end else if (run == CW'(FILTER_LEN - 1)) begin
        filt <= sync2;
        run  <= '0;
      end else begin
        run <= run + CW'(1);
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature front end: filters A/B/index, decodes step/direction, keeps the
// position count and the sticky err / idx_seen flags.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             idx_in,
  input  logic             ena,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             idx_zero_en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic             idx_seen
);

  logic        a_filt;
  logic        b_filt;
  logic        idx_filt;
  logic [1:0]  cur_ab;
  logic [1:0]  prev_ab;
  logic        idx_prev;
  logic        idx_rise;
  logic        valid_step;
  quad_event_e ev;

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .raw(a_in), .filt(a_filt)
  );
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .raw(b_in), .filt(b_filt)
  );
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_idx (
    .clk(clk), .rst(rst), .raw(idx_in), .filt(idx_filt)
  );

  assign cur_ab   = {b_filt, a_filt};
  assign idx_rise = idx_filt & ~idx_prev;

  always_comb begin
    ev = EV_NONE;
    if (cur_ab != prev_ab) begin
      if (cur_ab == next_up(prev_ab))      ev = EV_UP;
      else if (prev_ab == next_up(cur_ab)) ev = EV_DOWN;
      else                                 ev = EV_ILLEGAL;
    end
  end

  assign valid_step = (ev == EV_UP) || (ev == EV_DOWN);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ab  <= PH_00;
      idx_prev <= 1'b0;
      count    <= '0;
      step     <= 1'b0;
      dir      <= DIR_UP;
      err      <= 1'b0;
      idx_seen <= 1'b0;
    end else begin
      // prev_ab always follows, so an illegal jump resynchronises the decoder.
      prev_ab  <= cur_ab;
      idx_prev <= idx_filt;
      step     <= ena & valid_step;
      if (ev == EV_UP)   dir <= DIR_UP;
      if (ev == EV_DOWN) dir <= DIR_DOWN;
      if (ev == EV_ILLEGAL) err <= 1'b1;
      else if (clr_err)     err <= 1'b0;
      if (idx_rise) idx_seen <= 1'b1;
      // Load and index-zero override a coincident step; step/dir still report it.
      if (load)                          count <= load_val;
      else if (idx_rise && idx_zero_en)  count <= '0;
      else if (ena && (ev == EV_UP))     count <= count + WIDTH'(1);
      else if (ena && (ev == EV_DOWN))   count <= count - WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus a randomized walk
// compared against a position/phase model of the encoder.
module tb_quad_decoder;

  localparam int WIDTH      = 8;
  localparam int FILTER_LEN = 3;
  localparam int HOLD       = FILTER_LEN + 6;
  localparam int LAT        = 2 + FILTER_LEN + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_in;
  logic             b_in;
  logic             idx_in;
  logic             ena;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             idx_zero_en;
  logic             clr_err;
  logic [WIDTH-1:0] count;
  logic             step;
  logic             dir;
  logic             err;
  logic             idx_seen;

  quad_decoder #(.WIDTH(WIDTH), .FILTER_LEN(FILTER_LEN)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .idx_in(idx_in),
    .ena(ena), .load(load), .load_val(load_val), .idx_zero_en(idx_zero_en),
    .clr_err(clr_err), .count(count), .step(step), .dir(dir), .err(err),
    .idx_seen(idx_seen)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  // encoder position model: gray[pos] is the {B,A} level at that position
  logic [1:0]       gray [4];
  int               m_pos;
  logic [WIDTH-1:0] m_count;
  logic             m_dir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_window(input int n, output int pulses, output int first);
    pulses = 0;
    first  = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (step) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; a_in = 1'b0; b_in = 1'b0; idx_in = 1'b0;
    ena = 1'b1; load = 1'b0; load_val = '0; idx_zero_en = 1'b0; clr_err = 1'b0;
    tick(3);
    rst = 1'b0;
    m_pos = 0; m_count = '0; m_dir = 1'b0;
  endtask

  task automatic drive_pos(input int pos);
    {b_in, a_in} = gray[pos % 4];
  endtask

  task automatic pulse_clr_err();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  initial begin
    int pulses, first, total, kind;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exp_c;
    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;

    // reset values
    do_reset();
    check("rst_count", count, 0);
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_err", err, 0);
    check("rst_idx_seen", idx_seen, 0);

    // 1: sixteen forward edges, first one also checks latency
    total = 0;
    for (int e = 1; e <= 16; e++) begin
      drive_pos(e);
      run_window(HOLD, pulses, first);
      total += pulses;
      if (e == 1) check("latency", first, LAT);
    end
    check("fwd16_steps", total, 16);
    check("fwd16_count", count, 16);
    check("fwd16_dir", dir, 0);
    check("fwd16_err", err, 0);

    // 2: one reverse edge from zero wraps to max
    do_reset();
    drive_pos(3);
    run_window(HOLD, pulses, first);
    check("rev_steps", pulses, 1);
    check("rev_wrap_count", count, 8'hFF);
    check("rev_dir", dir, 1);

    // 3: glitch shorter than the filter, then exactly FILTER_LEN wide
    do_reset();
    base = count;
    a_in = 1'b1;
    tick(FILTER_LEN - 1);
    a_in = 1'b0;
    run_window(12, pulses, first);
    check("glitch_steps", pulses, 0);
    check("glitch_count", count, base);
    a_in = 1'b1;
    tick(FILTER_LEN);
    a_in = 1'b0;
    tick(2 + FILTER_LEN + 1 - FILTER_LEN + 1);
    check("narrow_mid_count", count, base + 8'd1);
    run_window(10, pulses, first);
    check("narrow_back_count", count, base);

    // 4: illegal jump, clr_err alone, clr_err with a new illegal jump
    do_reset();
    {b_in, a_in} = 2'b11;
    run_window(HOLD, pulses, first);
    check("ill_err", err, 1);
    check("ill_count", count, 0);
    check("ill_steps", pulses, 0);
    pulse_clr_err();
    check("clr_alone", err, 0);
    {b_in, a_in} = 2'b00;
    tick(LAT - 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_vs_ill", err, 1);
    tick(4);
    check("clr_vs_ill_count", count, 0);
    pulse_clr_err();
    check("clr_again", err, 0);

    // 5: load coincident with a forward step, then ena=0
    do_reset();
    drive_pos(1);
    tick(LAT - 1);
    load = 1'b1; load_val = 8'hA5;
    tick(1);
    load = 1'b0;
    check("load_count", count, 8'hA5);
    check("load_step", step, 1);
    check("load_dir", dir, 0);
    tick(4);
    check("load_hold", count, 8'hA5);
    ena = 1'b0;
    total = 0;
    for (int e = 2; e <= 4; e++) begin
      drive_pos(e);
      run_window(HOLD, pulses, first);
      total += pulses;
    end
    check("ena0_steps", total, 0);
    check("ena0_count", count, 8'hA5);
    ena = 1'b1;

    // 6: index zeroing enabled and disabled
    do_reset();
    load = 1'b1; load_val = 8'h3C;
    tick(1);
    load = 1'b0;
    idx_zero_en = 1'b1;
    idx_in = 1'b1;
    tick(HOLD);
    check("idx_zero_count", count, 0);
    check("idx_zero_seen", idx_seen, 1);
    do_reset();
    load = 1'b1; load_val = 8'h3C;
    tick(1);
    load = 1'b0;
    idx_in = 1'b1;
    tick(HOLD);
    check("idx_nozero_count", count, 8'h3C);
    check("idx_nozero_seen", idx_seen, 1);

    // randomized walk against the position model
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int exp_pulses;
      logic exp_err;
      kind = $urandom_range(0, 9);
      ena  = ($urandom_range(0, 3) != 0);
      exp_pulses = 0;
      exp_err = 1'b0;
      if (kind <= 3) begin
        m_pos = (m_pos + 1) % 4;
        m_dir = 1'b0;
        exp_pulses = ena ? 1 : 0;
        if (ena) m_count = m_count + 8'd1;
      end else if (kind <= 7) begin
        m_pos = (m_pos + 3) % 4;
        m_dir = 1'b1;
        exp_pulses = ena ? 1 : 0;
        if (ena) m_count = m_count - 8'd1;
      end else if (kind == 8) begin
        m_pos = (m_pos + 2) % 4;
        exp_err = 1'b1;
      end
      exp_q.push_back(m_count);
      drive_pos(m_pos);
      run_window(HOLD, pulses, first);
      exp_c = exp_q.pop_front();
      check("rnd_steps", pulses, exp_pulses);
      check("rnd_count", count, exp_c);
      check("rnd_dir", dir, m_dir);
      check("rnd_err", err, exp_err);
      if (exp_err) begin
        pulse_clr_err();
        check("rnd_clr", err, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
